lap_stash: RTL and testbench

- Parametrised sample/lap store for the stopwatch datapath: captures WIDTH-bit samples on sample_in_valid into a DEPTH-entry ring.
- Lets the user browse stored samples in both directions (next/prev) and reports fill level and overflow.
- Sits between the lap-capture logic and the display mux; sample_out feeds the 7-segment driver.
- Selectable full-policy: overwrite oldest (ring) or drop new (freeze).

---
 rtl/lap_stash_pkg.sv | 15 +
 rtl/lap_stash_ring_ptr.sv | 32 +++
 rtl/lap_stash.sv | 83 ++++++++
 tb/tb_lap_stash.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/lap_stash_pkg.sv
// rtl/lap_stash_pkg.sv - shared full-policy codes and width helpers for lap_stash
package lap_stash_pkg;

    localparam int MODE_OVERWRITE = 0;
    localparam int MODE_DROP      = 1;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lap_stash_ring_ptr.sv
// rtl/lap_stash_ring_ptr.sv - bounded ring pointer step: wraps hi->lo on inc, lo->hi on dec
module ring_ptr
    import lap_stash_pkg::*;
#(
    parameter  int DEPTH = 5,
    localparam int PTR_W = ptr_w(DEPTH)
) (
    input  logic [PTR_W-1:0] ptr,
    input  logic             inc,
    input  logic             dec,
    input  logic [PTR_W-1:0] lo,
    input  logic [PTR_W-1:0] hi,
    output logic [PTR_W-1:0] next_ptr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    // The window [lo..hi] may straddle the physical end, so stepping also wraps at DEPTH
    always_comb begin
        next_ptr = ptr;
        if (inc && !dec) begin
            if (ptr == hi)        next_ptr = lo;
            else if (ptr == LAST) next_ptr = '0;
            else                  next_ptr = ptr + 1'b1;
        end else if (dec && !inc) begin
            if (ptr == lo)        next_ptr = hi;
            else if (ptr == '0)   next_ptr = LAST;
            else                  next_ptr = ptr - 1'b1;
        end
    end

endmodule

// File: rtl/lap_stash.sv
// rtl/lap_stash.sv - DEPTH-entry lap sample ring with bidirectional browsing and overflow flag
module lap_stash
    import lap_stash_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 5,
    parameter  int MODE  = MODE_OVERWRITE,
    localparam int PTR_W = ptr_w(DEPTH),
    localparam int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_in_valid,
    input  logic             next_sample,
    input  logic             prev_sample,
    input  logic             clear,
    output logic [WIDTH-1:0] sample_out,
    output logic [PTR_W-1:0] out_index,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_next, rd_next, oldest, newest;

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign oldest = full ? wr_ptr : '0;
    assign newest = (wr_ptr == '0) ? PTR_W'(DEPTH - 1) : wr_ptr - 1'b1;

    ring_ptr #(.DEPTH(DEPTH)) u_wr_step (
        .ptr      (wr_ptr),
        .inc      (1'b1),
        .dec      (1'b0),
        .lo       ('0),
        .hi       (PTR_W'(DEPTH - 1)),
        .next_ptr (wr_next)
    );

    ring_ptr #(.DEPTH(DEPTH)) u_rd_step (
        .ptr      (rd_ptr),
        .inc      (next_sample),
        .dec      (prev_sample),
        .lo       (oldest),
        .hi       (newest),
        .next_ptr (rd_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (sample_in_valid) begin
            // A write always swallows any same-cycle browse strobe, even when dropped
            if (!full || MODE == MODE_OVERWRITE) begin
                mem[wr_ptr] <= sample_in;
                rd_ptr      <= wr_ptr;
                wr_ptr      <= wr_next;
                if (!full) count <= count + 1'b1;
            end
            if (full) overflow <= 1'b1;
        end else if (!empty) begin
            rd_ptr <= rd_next;
        end
    end

    assign sample_out = empty ? '0 : mem[rd_ptr];
    assign out_index  = (rd_ptr >= oldest) ? rd_ptr - oldest
                                           : rd_ptr - oldest + PTR_W'(DEPTH);

endmodule

// File: tb/tb_lap_stash.sv
// tb/tb_lap_stash.sv - randomized and directed checks of lap_stash against a queue model
module tb_lap_stash;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] s_in [3];
    logic        v [3], nx [3], pv [3], clr [3];
    logic [7:0]  so0, so1;
    logic [11:0] so2;
    logic [2:0]  ix0, ix1, cn0, cn1;
    logic [1:0]  ix2, cn2;
    logic        em [3], fu [3], ov [3];

    lap_stash #(.WIDTH(8), .DEPTH(5), .MODE(0)) dut0 (
        .clk(clk), .reset(rst_n), .sample_in(s_in[0][7:0]), .sample_in_valid(v[0]),
        .next_sample(nx[0]), .prev_sample(pv[0]), .clear(clr[0]), .sample_out(so0),
        .out_index(ix0), .count(cn0), .empty(em[0]), .full(fu[0]), .overflow(ov[0]));

    lap_stash #(.WIDTH(8), .DEPTH(5), .MODE(1)) dut1 (
        .clk(clk), .reset(rst_n), .sample_in(s_in[1][7:0]), .sample_in_valid(v[1]),
        .next_sample(nx[1]), .prev_sample(pv[1]), .clear(clr[1]), .sample_out(so1),
        .out_index(ix1), .count(cn1), .empty(em[1]), .full(fu[1]), .overflow(ov[1]));

    lap_stash #(.WIDTH(12), .DEPTH(3), .MODE(0)) dut2 (
        .clk(clk), .reset(rst_n), .sample_in(s_in[2][11:0]), .sample_in_valid(v[2]),
        .next_sample(nx[2]), .prev_sample(pv[2]), .clear(clr[2]), .sample_out(so2),
        .out_index(ix2), .count(cn2), .empty(em[2]), .full(fu[2]), .overflow(ov[2]));

    // Reference: queue holds stored samples oldest-first; midx is the browsed age position
    int unsigned mq [3][$];
    int          midx [3];
    bit          movf [3];
    int          dep [3]   = '{5, 5, 3};
    int          mmode [3] = '{0, 1, 0};
    int unsigned mask [3]  = '{32'hff, 32'hff, 32'hfff};

    int passed = 0;
    int failed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int i);
        mq[i].delete();
        midx[i] = 0;
        movf[i] = 1'b0;
    endtask

    task automatic model_step(input int i, input int unsigned val, input bit w,
                              input bit n, input bit p, input bit c);
        int sz;
        sz = mq[i].size();
        if (c) begin
            model_reset(i);
        end else if (w) begin
            if (sz < dep[i]) begin
                mq[i].push_back(val & mask[i]);
                midx[i] = sz;
            end else begin
                movf[i] = 1'b1;
                if (mmode[i] == 0) begin
                    void'(mq[i].pop_front());
                    mq[i].push_back(val & mask[i]);
                    midx[i] = dep[i] - 1;
                end
            end
        end else if (sz > 0 && n != p) begin
            midx[i] = n ? (midx[i] + 1) % sz : (midx[i] + sz - 1) % sz;
        end
    endtask

    task automatic check_all(input int i);
        logic [31:0] so, ix, cn;
        int          sz;
        string       t;
        case (i)
            0:       begin so = 32'(so0); ix = 32'(ix0); cn = 32'(cn0); end
            1:       begin so = 32'(so1); ix = 32'(ix1); cn = 32'(cn1); end
            default: begin so = 32'(so2); ix = 32'(ix2); cn = 32'(cn2); end
        endcase
        sz = mq[i].size();
        t  = $sformatf("u%0d_", i);
        chk({t, "sample_out"}, so, (sz == 0) ? 32'd0 : mq[i][midx[i]]);
        chk({t, "out_index"}, ix, 32'(midx[i]));
        chk({t, "count"}, cn, 32'(sz));
        chk({t, "empty"}, 32'(em[i]), 32'(sz == 0));
        chk({t, "full"}, 32'(fu[i]), 32'(sz == dep[i]));
        chk({t, "overflow"}, 32'(ov[i]), 32'(movf[i]));
    endtask

    task automatic step(input int i, input int unsigned val, input bit w,
                        input bit n, input bit p, input bit c);
        s_in[i] = val[15:0];
        v[i]    = w;
        nx[i]   = n;
        pv[i]   = p;
        clr[i]  = c;
        @(posedge clk);
        model_step(i, val, w, n, p, c);
        #1;
        v[i]   = 1'b0;
        nx[i]  = 1'b0;
        pv[i]  = 1'b0;
        clr[i] = 1'b0;
        check_all(i);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_in[i] = '0; v[i] = 1'b0; nx[i] = 1'b0; pv[i] = 1'b0; clr[i] = 1'b0;
            model_reset(i);
        end
        #12;
        for (int i = 0; i < 3; i++) check_all(i);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 1; k <= 5; k++) step(0, 32'h11 * k, 1, 0, 0, 0);
        chk("fill_so", 32'(so0), 32'h55);
        chk("fill_idx", 32'(ix0), 32'd4);
        chk("fill_full", 32'(fu[0]), 32'd1);
        step(0, 0, 0, 1, 0, 0);
        chk("next_wrap_so", 32'(so0), 32'h11);
        step(0, 0, 0, 0, 1, 0);
        chk("prev_wrap_so", 32'(so0), 32'h55);
        step(0, 32'h66, 1, 0, 0, 0);
        chk("ovw_so", 32'(so0), 32'h66);
        chk("ovw_flag", 32'(ov[0]), 32'd1);
        step(0, 0, 0, 1, 0, 0);
        chk("evicted_so", 32'(so0), 32'h22);
        chk("evicted_idx", 32'(ix0), 32'd0);
        step(0, 32'h77, 1, 1, 0, 0);
        chk("wr_beats_next", 32'(so0), 32'h77);
        step(0, 0, 0, 1, 1, 0);
        step(0, 32'h88, 1, 0, 0, 1);
        chk("clear_count", 32'(cn0), 32'd0);
        chk("clear_ovf", 32'(ov[0]), 32'd0);

        for (int k = 1; k <= 5; k++) step(1, 32'h11 * k, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0);
        step(1, 32'h66, 1, 0, 0, 0);
        chk("drop_so", 32'(so1), 32'h44);
        chk("drop_ovf", 32'(ov[1]), 32'd1);
        step(1, 32'h99, 1, 1, 0, 0);
        chk("drop_browse_held", 32'(so1), 32'h44);

        step(2, 32'habc, 1, 0, 0, 0);
        step(2, 32'h123, 1, 0, 0, 0);
        chk("wrap3_so0", 32'(so2), 32'h123);
        step(2, 0, 0, 0, 1, 0);
        chk("wrap3_so1", 32'(so2), 32'habc);
        chk("wrap3_ix1", 32'(ix2), 32'd0);
        step(2, 0, 0, 0, 1, 0);
        chk("wrap3_so2", 32'(so2), 32'h123);
        chk("wrap3_ix2", 32'(ix2), 32'd1);
        step(2, 0, 0, 0, 1, 0);
        chk("wrap3_so3", 32'(so2), 32'habc);

        step(0, 32'h5a, 1, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            model_reset(i);
            check_all(i);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 1, 0, 0);
        chk("empty_next_so", 32'(so0), 32'd0);

        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 250; k++) begin
                int r;
                r = int'($urandom_range(0, 99));
                step(i, $urandom, r < 45, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), r >= 97);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
